// File: rtl/bitserial_op_sequencer.sv
// Bit-serial sequencer for a 2-input programmable function stage.
// It accepts {op, A, B}, walks the operand bits LSB first and returns the collected result word.
module bitserial_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       fn_sel,
  output logic             fn_x,
  output logic             fn_y,
  input  logic             fn_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_bit_s;
  logic [WIDTH-1:0]   res_shift_s;

  assign last_bit_s = (state_q == S_RUN) && (cnt_q == CNT_LAST);

  // A one-bit result has no upper slice to shift down, so it is just the returned z bit.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift_s = fn_z;
  end else begin : g_res_wn
    assign res_shift_s = {fn_z, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_bit_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fn_sel    = 4'b0000;
    fn_x      = 1'b0;
    fn_y      = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        fn_sel = op_q;
        fn_x   = a_q[0];
        fn_y   = b_q[0];
      end
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // The published result lives apart from res_q so it survives the clear on the next accept.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          a_d   = in_a;
          b_d   = in_b;
          res_d = '0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        res_d = res_shift_s;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        if (last_bit_s) begin
          result_d = res_shift_s;
          cnt_d    = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 4'b0000;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign out_result = result_q;

endmodule

// File: tb/tb_bitserial_op_sequencer.sv
// Directed plus randomized bench for bitserial_op_sequencer (WIDTH=8 and WIDTH=1 instances).
// The function stage and the word-level reference are modelled here from the truth-table rule.
module tb_bitserial_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8, ir8, fx8, fy8, fz8, ov8, or8;
  logic [3:0] op8, fs8;
  logic [7:0] a8, b8, res8;

  logic       iv1, ir1, fx1, fy1, fz1, ov1, or1;
  logic [3:0] op1, fs1;
  logic [0:0] a1, b1, res1;

  logic zr_en, zr;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last8;

  // sel is a truth table listed from {x,y}=00 at bit 3 down to {x,y}=11 at bit 0.
  function automatic logic fstage(input logic [3:0] s, input logic x, input logic y);
    int row;
    row = 2 * (x ? 1 : 0) + (y ? 1 : 0);
    return s[3 - row];
  endfunction

  function automatic logic [7:0] ref8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = fstage(op, a[i], b[i]);
    return r;
  endfunction

  assign fz8 = zr_en ? zr : fstage(fs8, fx8, fy8);
  assign fz1 = zr_en ? zr : fstage(fs1, fx1, fy1);

  bitserial_op_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_op(op8), .in_a(a8), .in_b(b8),
    .fn_sel(fs8), .fn_x(fx8), .fn_y(fy8), .fn_z(fz8),
    .out_valid(ov8), .out_ready(or8), .out_result(res8)
  );

  bitserial_op_sequencer #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_op(op1), .in_a(a1), .in_b(b1),
    .fn_sel(fs1), .fn_x(fx1), .fn_y(fy1), .fn_z(fz1),
    .out_valid(ov1), .out_ready(or1), .out_result(res1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit command: accept, eight RUN cycles, optional stall in DONE, handshake.
  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int stall);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b;
    chk("ir_idle8", 32'(ir8), 32'd1);
    @(posedge clk); #1;
    iv8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fn_sel_run", 32'(fs8), 32'(op));
      chk("fn_x_run", 32'(fx8), 32'(a[i]));
      chk("fn_y_run", 32'(fy8), 32'(b[i]));
      chk("ov_run", 32'(ov8), 32'd0);
      chk("ir_run", 32'(ir8), 32'd0);
      @(posedge clk); #1;
    end
    for (int s = 0; s < stall; s++) begin
      iv8 = 1'b1;
      @(negedge clk);
      chk("ov_stall", 32'(ov8), 32'd1);
      chk("res_stall", 32'(res8), 32'(exp));
      chk("ir_stall", 32'(ir8), 32'd0);
      chk("fn_sel_done", 32'(fs8), 32'd0);
      @(posedge clk); #1;
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    chk("ov_done", 32'(ov8), 32'd1);
    chk("res_done", 32'(res8), 32'(exp));
    @(posedge clk); #1;
    or8 = 1'b0;
    @(negedge clk);
    chk("ov_after", 32'(ov8), 32'd0);
    chk("ir_after", 32'(ir8), 32'd1);
    chk("res_hold", 32'(res8), 32'(exp));
    last8 = exp;
  endtask

  task automatic run1(input logic [3:0] op, input logic a, input logic b, input logic exp);
    iv1 = 1'b1; op1 = op; a1 = a; b1 = b;
    chk("ir_idle1", 32'(ir1), 32'd1);
    @(posedge clk); #1;
    iv1 = 1'b0; op1 = 4'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
    @(negedge clk);
    chk("fn_sel1", 32'(fs1), 32'(op));
    chk("fn_x1", 32'(fx1), 32'(a));
    chk("fn_y1", 32'(fy1), 32'(b));
    chk("ov_run1", 32'(ov1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ov_done1", 32'(ov1), 32'd1);
    chk("res_done1", 32'(res1), 32'(exp));
    chk("ir_done1", 32'(ir1), 32'd0);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    @(negedge clk);
    chk("ov_after1", 32'(ov1), 32'd0);
    chk("ir_after1", 32'(ir1), 32'd1);
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] a, b;
    iv8 = 1'b0; op8 = 4'd0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b0;
    iv1 = 1'b0; op1 = 4'd0; a1 = 1'b0; b1 = 1'b0; or1 = 1'b0;
    zr_en = 1'b0; zr = 1'b0; last8 = 8'd0;

    #2;
    chk("rst_ir", 32'(ir8), 32'd1);
    chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_res", 32'(res8), 32'd0);
    chk("rst_sel", 32'(fs8), 32'd0);
    chk("rst_x", 32'(fx8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ir", 32'(ir8), 32'd1);

    run8(4'b0110, 8'hA5, 8'h3C, 8'h99, 0);
    run8(4'b0001, 8'hF0, 8'hCC, 8'hC0, 0);
    run8(4'b1111, 8'($urandom), 8'($urandom), 8'hFF, 0);
    a = 8'($urandom); b = 8'($urandom);
    run8(4'b0110, a, b, ref8(4'b0110, a, b), 5);

    for (int n = 0; n < 16; n++) begin
      op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      run8(op, a, b, ref8(op, a, b), int'($urandom_range(0, 3)));
    end

    // Abort a command partway through RUN.
    iv8 = 1'b1; op8 = 4'b1001; a8 = 8'h5A; b8 = 8'h77;
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_sel", 32'(fs8), 32'd0);
    chk("abort_x", 32'(fx8), 32'd0);
    chk("abort_y", 32'(fy8), 32'd0);
    chk("abort_ov", 32'(ov8), 32'd0);
    chk("abort_res", 32'(res8), 32'd0);
    chk("abort_ir", 32'(ir8), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_ov", 32'(ov8), 32'd0);
      chk("abort_ir_rel", 32'(ir8), 32'd1);
    end
    run8(4'b0111, 8'h0F, 8'h30, 8'h3F, 0);

    // Idle with a noisy fn_z.
    zr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      zr = 1'($urandom);
      @(negedge clk);
      chk("idle_sel", 32'(fs8), 32'd0);
      chk("idle_x", 32'(fx8), 32'd0);
      chk("idle_y", 32'(fy8), 32'd0);
      chk("idle_ov", 32'(ov8), 32'd0);
      chk("idle_res", 32'(res8), 32'(last8));
      @(posedge clk); #1;
    end
    zr_en = 1'b0;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom);
    run8(4'b1000, a, b, ref8(4'b1000, a, b), 1);

    run1(4'b1100, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      logic x, y;
      op = 4'($urandom); x = 1'($urandom); y = 1'($urandom);
      run1(op, x, y, fstage(op, x, y));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
